// File: rtl/pilot_pkg.sv
// Shared definitions for the pilot scheduler: FSM states, PRBS-9 seed,
// pilot constellation amplitudes and the default length-counter width.
package pilot_pkg;

    // Frame sequencing states
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PILOT = 2'd1,
        DATA  = 2'd2
    } state_t;

    // Default width of frame_length and of the data-beat counter
    localparam int unsigned LEN_W = 13;

    // PRBS-9 generator (x^9 + x^5 + 1), restarted at every frame
    localparam int unsigned PRBS_W    = 9;
    localparam logic [8:0]  PRBS_SEED = 9'h1FF;

    // BPSK pilot amplitudes on I; Q is always zero
    localparam logic [15:0] PILOT_AMP_POS = 16'h4000;
    localparam logic [15:0] PILOT_AMP_NEG = 16'hC000;
    localparam logic [15:0] PILOT_Q       = 16'h0000;

    // Map one PRBS bit onto a packed {I, Q} pilot beat
    function automatic logic [31:0] pilot_iq(input logic b);
        logic [31:0] iq;
        if (b) begin
            iq = {PILOT_AMP_NEG, PILOT_Q};
        end else begin
            iq = {PILOT_AMP_POS, PILOT_Q};
        end
        return iq;
    endfunction

    // One shift of the PRBS-9 register: output is bit 8, feedback enters bit 0
    function automatic logic [8:0] prbs9_next(input logic [8:0] s);
        return {s[7:0], s[8] ^ s[4]};
    endfunction

endpackage

// File: rtl/pilot_prbs.sv
// PRBS-9 source for the pilot symbols. Holds its value until told to advance,
// so a stalled pilot beat keeps presenting the same symbol.
module pilot_prbs
    import pilot_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic reseed,
    input  logic advance,
    output logic prbs_bit
);

    logic [PRBS_W-1:0] lfsr_r;

    // LFSR state: seed on reset or frame restart, shift once per accepted pilot
    always_ff @(posedge clk) begin
        if (!rst) begin
            lfsr_r <= PRBS_SEED;
        end else if (reseed) begin
            lfsr_r <= PRBS_SEED;
        end else if (advance) begin
            lfsr_r <= prbs9_next(lfsr_r);
        end else begin
            lfsr_r <= lfsr_r;
        end
    end

    assign prbs_bit = lfsr_r[PRBS_W-1];

endmodule

// File: rtl/pilot_scheduler.sv
// Frames a source IQ stream: each frame is pilot_length PRBS-9 BPSK pilot
// beats followed by frame_length data beats passed straight through from the
// source. Lengths are captured when a frame starts and held until it ends.
module pilot_scheduler #(
    parameter int DATA_W = 32,
    parameter int LEN_W  = pilot_pkg::LEN_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic [LEN_W-1:0]  frame_length,
    input  logic [7:0]        pilot_length,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    output logic              s_tready,
    output logic [DATA_W-1:0] m_tdata,
    output logic              m_tvalid,
    input  logic              m_tready,
    output logic              m_tlast,
    output logic              pilot_flag,
    output logic              start_frame,
    output logic              end_frame
);

    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = LEN_W'(1);

    pilot_pkg::state_t state_r;
    logic [7:0]        plen_r;
    logic [LEN_W-1:0]  flen_r;
    logic [7:0]        pilot_cnt_r;
    logic [LEN_W-1:0]  data_cnt_r;

    logic              prbs_bit_s;
    logic              prbs_reseed_s;
    logic              prbs_advance_s;
    logic              xfer_s;
    logic              pilot_last_s;
    logic              data_last_s;
    logic [DATA_W-1:0] pilot_word_s;

    // Sequence position decode shared by the FSM and the output flags
    always_comb begin
        xfer_s       = m_tvalid & m_tready;
        pilot_last_s = (pilot_cnt_r == (plen_r - 8'd1));
        data_last_s  = (data_cnt_r == (flen_r - LEN_ONE));
        pilot_word_s = DATA_W'(pilot_pkg::pilot_iq(prbs_bit_s));
    end

    // PRBS control: restart every time we sit in IDLE, step on each pilot handshake
    always_comb begin
        prbs_reseed_s  = 1'b0;
        prbs_advance_s = 1'b0;
        if (state_r == pilot_pkg::IDLE) begin
            prbs_reseed_s = 1'b1;
        end else if ((state_r == pilot_pkg::PILOT) && xfer_s) begin
            prbs_advance_s = 1'b1;
        end else begin
            prbs_advance_s = 1'b0;
        end
    end

    pilot_prbs u_prbs (
        .clk      (clk),
        .rst      (rst),
        .reseed   (prbs_reseed_s),
        .advance  (prbs_advance_s),
        .prbs_bit (prbs_bit_s)
    );

    // Frame sequencer: latch lengths in IDLE, count pilots then data beats
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= pilot_pkg::IDLE;
            plen_r      <= 8'd0;
            flen_r      <= LEN_ZERO;
            pilot_cnt_r <= 8'd0;
            data_cnt_r  <= LEN_ZERO;
        end else begin
            case (state_r)
                pilot_pkg::IDLE: begin
                    pilot_cnt_r <= 8'd0;
                    data_cnt_r  <= LEN_ZERO;
                    if (en && (frame_length != LEN_ZERO)) begin
                        plen_r <= pilot_length;
                        flen_r <= frame_length;
                        if (pilot_length == 8'd0) begin
                            state_r <= pilot_pkg::DATA;
                        end else begin
                            state_r <= pilot_pkg::PILOT;
                        end
                    end else begin
                        state_r <= pilot_pkg::IDLE;
                    end
                end
                pilot_pkg::PILOT: begin
                    if (xfer_s) begin
                        if (pilot_last_s) begin
                            pilot_cnt_r <= 8'd0;
                            state_r     <= pilot_pkg::DATA;
                        end else begin
                            pilot_cnt_r <= pilot_cnt_r + 8'd1;
                        end
                    end else begin
                        pilot_cnt_r <= pilot_cnt_r;
                    end
                end
                pilot_pkg::DATA: begin
                    if (xfer_s) begin
                        if (data_last_s) begin
                            data_cnt_r <= LEN_ZERO;
                            state_r    <= pilot_pkg::IDLE;
                        end else begin
                            data_cnt_r <= data_cnt_r + LEN_ONE;
                        end
                    end else begin
                        data_cnt_r <= data_cnt_r;
                    end
                end
                default: begin
                    state_r     <= pilot_pkg::IDLE;
                    pilot_cnt_r <= 8'd0;
                    data_cnt_r  <= LEN_ZERO;
                end
            endcase
        end
    end

    // Stream outputs: pilots come from the PRBS, data passes through with no latency
    always_comb begin
        m_tdata     = {DATA_W{1'b0}};
        m_tvalid    = 1'b0;
        s_tready    = 1'b0;
        pilot_flag  = 1'b0;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        case (state_r)
            pilot_pkg::PILOT: begin
                m_tdata    = pilot_word_s;
                m_tvalid   = 1'b1;
                pilot_flag = 1'b1;
                if (pilot_cnt_r == 8'd0) begin
                    start_frame = 1'b1;
                end else begin
                    start_frame = 1'b0;
                end
            end
            pilot_pkg::DATA: begin
                m_tdata   = s_tdata;
                m_tvalid  = s_tvalid;
                s_tready  = m_tready;
                end_frame = data_last_s;
                if ((plen_r == 8'd0) && (data_cnt_r == LEN_ZERO)) begin
                    start_frame = 1'b1;
                end else begin
                    start_frame = 1'b0;
                end
            end
            default: begin
                m_tdata = {DATA_W{1'b0}};
            end
        endcase
        m_tlast = end_frame;
    end

endmodule

// File: doc/pilot_scheduler.md
PILOT_SCHEDULER -- requirements
Module: pilot_scheduler

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning width of one IQ beat (I in [31:16], Q in [15:0]).
REQ-002 SHALL have parameter LEN_W, default 13, meaning width of frame_length and the data counter.
REQ-003 SHALL have port clk  input  1  sole clock; all logic on rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port en  input  1  frame generation enable, sampled only in IDLE.
REQ-006 SHALL have port frame_length  input  LEN_W  data beats per frame, sampled in IDLE.
REQ-007 SHALL have port pilot_length  input  8  pilot beats per frame preamble, sampled in IDLE.
REQ-008 SHALL have ports s_tdata/s_tvalid/s_tready  in/in/out  DATA_W/1/1  source data stream.
REQ-009 SHALL have ports m_tdata/m_tvalid/m_tready/m_tlast  out/out/in/out  DATA_W/1/1/1  framed output stream.
REQ-010 SHALL have port pilot_flag  output  1  current m_tdata beat is a pilot.
REQ-011 SHALL have port start_frame  output  1  current m_tdata beat is the first beat of a frame.
REQ-012 SHALL have port end_frame  output  1  current m_tdata beat is the last beat of a frame (equals m_tlast).

Function
REQ-013 SHALL implement FSM states IDLE, PILOT, DATA; a beat is transferred when m_tvalid and m_tready are both high.
REQ-014 In IDLE with en=1 and frame_length!=0, SHALL latch both lengths and go to PILOT, or to DATA if pilot_length==0; otherwise SHALL stay in IDLE.
REQ-015 In PILOT, SHALL drive m_tvalid=1, s_tready=0, pilot_flag=1, and keep m_tdata stable until transfer.
REQ-016 SHALL leave PILOT for DATA on the transfer of pilot beat pilot_length-1.
REQ-017 In DATA, SHALL pass combinationally with zero latency: m_tdata=s_tdata, m_tvalid=s_tvalid, s_tready=m_tready.
REQ-018 SHALL assert m_tlast/end_frame on data beat frame_length-1, and SHALL return to IDLE on its transfer.
REQ-019 SHALL assert start_frame on beat 0 of the frame: pilot 0, or data 0 when pilot_length==0.
REQ-020 With pilot_length=0 and frame_length=1, start_frame and end_frame SHALL both be high on the single beat.
REQ-021 Pilot value: bit b = lfsr[8] of PRBS-9 (x^9+x^5+1) seeded 9'h1FF at each frame start; SHALL advance once per pilot transfer.
REQ-022 Pilot mapping: b=0 -> I=16'h4000, b=1 -> I=16'hC000; Q=16'h0000 always.
REQ-023 Length changes mid-frame SHALL be ignored until the next IDLE; en=0 mid-frame SHALL let the current frame complete.
REQ-024 Pilot counter SHALL be 8 bits and data counter LEN_W bits; neither SHALL wrap within a frame.
REQ-025 IDLE SHALL last exactly one cycle between back-to-back frames while en=1.

Reset
REQ-026 On rst=0 at a clock edge, SHALL set state IDLE, counters 0, LFSR 9'h1FF, and m_tvalid, s_tready, m_tlast, pilot_flag, start_frame, end_frame all 0, regardless of a frame in progress.
REQ-027 SHALL drive m_tdata to 0 whenever state is IDLE.

Structure
REQ-028 Package pilot_pkg SHALL hold the state enum, PRBS seed 9'h1FF, the pilot amplitudes 16'h4000/16'hC000, and LEN_W.
REQ-029 SHALL instantiate one sub-module pilot_prbs holding the LFSR, with ports for clock, reset, reseed, advance, and bit.

Verification
REQ-030 pilot_length=4, frame_length=8, en=1, m_tready=1, s_tvalid=1 -> 12 beats: pilot_flag on beats 0-3, start_frame on beat 0, tlast on beat 11, then 1 idle cycle.
REQ-031 Pilot sequence check -> I values of frame pilots 0-3 match PRBS-9 from seed 1FF (first = 16'hC000), Q=0, and repeat identically in frame 2.
REQ-032 m_tready low for 3 cycles during pilot 2 -> m_tdata and pilot_flag held stable; no LFSR advance; beat count still 12.
REQ-033 pilot_length=0, frame_length=1 -> each output beat has start_frame=end_frame=m_tlast=1 and pilot_flag=0.
REQ-034 rst=0 asserted at data beat 5 -> next cycle all outputs 0, state IDLE; next frame starts with pilot I=16'hC000.
REQ-035 frame_length changed 8->3 mid-frame and en dropped mid-frame -> current frame keeps 8 data beats, then FSM stays in IDLE.
